// File: rtl/alu_iter_exec.sv
// Multi-cycle RV32I execute unit: single-cycle logic/arith ops,
// iterative shifts of up to SHIFT_STEP positions per cycle.
module alu_iter_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int SW = $clog2(XLEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic [1:0]      state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc;
  logic [SW-1:0]   rem;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            ill_q;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_shift;
  logic            is_ill;

  logic [SW-1:0]   step;
  logic [SW-1:0]   rem_nxt;
  logic [XLEN-1:0] acc_nxt;

  assign shamt = b_i[SW-1:0];

  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    is_ill   = 1'b0;
    case (op_i)
      OP_ADD:  alu_res = a_i + b_i;
      OP_SUB:  alu_res = a_i - b_i;
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SLL,
      OP_SRL,
      OP_SRA: begin
        // Zero shamt completes directly with a unchanged.
        is_shift = 1'b1;
        alu_res  = a_i;
      end
      OP_SLT:
        alu_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU:
        alu_res = {{(XLEN-1){1'b0}}, a_i < b_i};
      default: is_ill = 1'b1;
    endcase
  end

  always_comb begin
    step    = (rem < SW'(SHIFT_STEP)) ? rem : SW'(SHIFT_STEP);
    rem_nxt = rem - step;
    case (op_q)
      OP_SLL:  acc_nxt = acc << step;
      OP_SRA:  acc_nxt = $signed(acc) >>> step;
      default: acc_nxt = acc >> step;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_q     <= '0;
      acc      <= '0;
      rem      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_q <= op_i;
            if (is_shift && shamt != '0) begin
              acc   <= a_i;
              rem   <= shamt;
              state <= SHIFT;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              ill_q    <= is_ill;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            result_q <= acc_nxt;
            zero_q   <= (acc_nxt == '0);
            ill_q    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE) && !rst_i;
  assign out_valid_o = (state == DONE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = ill_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec
// (SHIFT_STEP=1 main instance, SHIFT_STEP=4 second instance).
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid4 = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;
  logic        out_ready4 = 1'b0;

  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic        in_ready4, out_valid4, zero4, illegal4;
  logic [31:0] result4;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_iter_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .illegal_o(illegal)
  );

  alu_iter_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4),
    .result_o(result4), .zero_o(zero4), .illegal_o(illegal4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for accept, then count edges until out_valid.
  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int l);
    int n;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1. ADD wraparound with out_ready held high
    out_ready = 1'b1;
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, lat);
    chk("add_lat", lat, 1);
    chk("add_result", result, 32'h0);
    chk("add_zero", zero, 1);
    tick();
    chk("add_handshake_valid", out_valid, 0);
    out_ready = 1'b0;

    // 2. Compares and SUB
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_result", result, 32'd1);
    consume();
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu_result", result, 32'd0);
    chk("sltu_zero", zero, 1);
    consume();
    issue(4'd1, 32'd5, 32'd7, lat);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero", zero, 0);
    consume();
    issue(4'd2, 32'hF0F0_F0F0, 32'h0FF0_FF00, lat);
    chk("and_result", result, 32'h00F0_F000);
    consume();
    issue(4'd3, 32'hF000_0000, 32'h0000_000F, lat);
    chk("or_result", result, 32'hF000_000F);
    consume();

    // 3. Iterative shifts
    issue(4'd7, 32'h8000_0000, 32'd31, lat);
    chk("sra31_lat", lat, 32);
    chk("sra31_result", result, 32'hFFFF_FFFF);
    consume();
    issue(4'd7, 32'h8000_0000, 32'h20, lat);
    chk("sra_shamt0_lat", lat, 1);
    chk("sra_shamt0_result", result, 32'h8000_0000);
    consume();
    issue(4'd6, 32'hF000_0000, 32'd4, lat);
    chk("srl4_lat", lat, 5);
    chk("srl4_result", result, 32'h0F00_0000);
    consume();

    op = 4'd7;
    a = 32'h8000_0000;
    b = 32'd31;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 200) begin
      tick();
      lat++;
    end
    chk("sra31_step4_lat", lat, 9);
    chk("sra31_step4_result", result4, 32'hFFFF_FFFF);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("step4_handshake_valid", out_valid4, 0);

    // 4. Backpressure: XOR pending while a new request waits
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_00FF, lat);
    chk("xor_result", result, 32'hFF00_12CB);
    op = 4'd0;
    a = 32'd10;
    b = 32'd20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result_stable", result, 32'hFF00_12CB);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", result, 32'd30);
    consume();

    // 5. Reset in the middle of a shift
    op = 4'd5;
    a = 32'd1;
    b = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    tick();
    chk("midrst_stays_idle", out_valid, 0);
    issue(4'd0, 32'd2, 32'd3, lat);
    chk("after_rst_add", result, 32'd5);
    consume();

    // 6. Illegal op, then a legal op clears the flag
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_result", result, 0);
    chk("ill_zero", zero, 1);
    consume();
    issue(4'd5, 32'h0000_0003, 32'd2, lat);
    chk("sll_after_ill", result, 32'h0000_000C);
    chk("ill_cleared", illegal, 0);
    chk("sll_lat", lat, 3);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
